// File: rtl/binary_erosion_3x3_if.sv
// binary_erosion_3x3_if: pixel-in / pixel-out stream bundle for the erosion stage.
interface binary_erosion_3x3_if;
    logic       ena;
    logic       frame_start;
    logic [7:0] in_px;
    logic       in_ready;
    logic [7:0] out_px;
    logic       out_valid;
    logic       out_frame_start;

    modport master (
        output ena, frame_start, in_px,
        input  in_ready, out_px, out_valid, out_frame_start
    );

    modport slave (
        input  ena, frame_start, in_px,
        output in_ready, out_px, out_valid, out_frame_start
    );
endinterface

// File: rtl/binary_erosion_3x3.sv
// binary_erosion_3x3: streaming 3x3 binary erosion over two 1-bit line buffers.
// Each output is registered one cycle after its window completes.
module binary_erosion_3x3 #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input logic                  CLK100MHZ,
    input logic                  btn_reset,
    binary_erosion_3x3_if.slave  bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT + 2);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] col, pos_col, pcol, ocol_n;
    logic [RW-1:0] row, pos_row, prow, orow_n;
    logic          lb1 [IMG_WIDTH];
    logic          lb2 [IMG_WIDTH];
    logic [2:0]    top, mid, bot;
    logic          accept, start, restart, shift, px, wrap;
    logic          last_in, last_flush, emit, pend, interior;
    logic          unused_bits;

    assign unused_bits  = ^bus.in_px[6:0];
    assign bus.in_ready = state != FLUSH;

    always_comb begin
        accept     = bus.ena && bus.in_ready;
        start      = accept && bus.frame_start;
        restart    = start && state == RUN;
        shift      = start || (accept && state == RUN) || state == FLUSH;
        px         = state != FLUSH && bus.in_px[7];
        pos_col    = start ? '0 : col;
        pos_row    = start ? '0 : row;
        wrap       = pos_col == CW'(IMG_WIDTH - 1);
        last_in    = state == RUN && accept && !start && wrap && pos_row == RW'(IMG_HEIGHT - 1);
        last_flush = state == FLUSH && pos_row == RW'(IMG_HEIGHT + 1);
        emit       = pos_row > RW'(1) || (pos_row == RW'(1) && pos_col != '0);
        ocol_n     = pos_col != '0 ? pos_col - CW'(1) : CW'(IMG_WIDTH - 1);
        orow_n     = pos_col != '0 ? pos_row - RW'(1) : pos_row - RW'(2);
        interior   = prow != '0 && prow != RW'(IMG_HEIGHT - 1) &&
                     pcol != '0 && pcol != CW'(IMG_WIDTH - 1);
    end

    // Line buffers carry no reset: stale contents only reach masked border outputs.
    always_ff @(posedge CLK100MHZ) begin
        if (shift) begin
            lb1[pos_col] <= px;
            lb2[pos_col] <= lb1[pos_col];
        end
    end

    always_ff @(posedge CLK100MHZ or negedge btn_reset) begin
        if (!btn_reset) begin
            state               <= IDLE;
            col                 <= '0;
            row                 <= '0;
            top                 <= '0;
            mid                 <= '0;
            bot                 <= '0;
            prow                <= '0;
            pcol                <= '0;
            pend                <= 1'b0;
            bus.out_valid       <= 1'b0;
            bus.out_px          <= 8'h00;
            bus.out_frame_start <= 1'b0;
        end else begin
            if (shift) begin
                col  <= (wrap || last_flush) ? '0 : pos_col + CW'(1);
                row  <= last_flush ? '0 : wrap ? pos_row + RW'(1) : pos_row;
                top  <= {top[1:0], lb2[pos_col]};
                mid  <= {mid[1:0], lb1[pos_col]};
                bot  <= {bot[1:0], px};
                prow <= orow_n;
                pcol <= ocol_n;
            end
            pend  <= shift && emit;
            state <= start ? RUN : last_in ? FLUSH : last_flush ? IDLE : state;
            // A restart swallows the output still in flight from the aborted frame.
            bus.out_valid       <= pend && !restart;
            bus.out_px          <= (pend && !restart && (&{top, mid, bot}) && interior) ? 8'hFF : 8'h00;
            bus.out_frame_start <= pend && !restart && prow == '0 && pcol == '0;
        end
    end
endmodule

// File: tb/tb_binary_erosion_3x3.sv
// tb_binary_erosion_3x3: table-driven frames plus restart/reset sequences,
// checked against an image-level erosion model.
module tb_binary_erosion_3x3;
    localparam int W = 8;
    localparam int H = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    binary_erosion_3x3_if bus();
    binary_erosion_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .CLK100MHZ(clk),
        .btn_reset(rst_n),
        .bus(bus)
    );

    typedef struct {
        int kind;
        int gap;
        int ones;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int n_acc = 0;
    int first_acc = 0;
    logic [7:0] oq[$];
    logic fq[$];
    bit img[H][W];
    vec_t vecs[6];

    always @(posedge clk) begin
        #2;
        if (bus.out_valid) begin
            if (oq.size() == 0) first_acc = n_acc;
            oq.push_back(bus.out_px);
            fq.push_back(bus.out_frame_start);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model(input int r, input int c);
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!img[r + dr][c + dc]) return 0;
        return 255;
    endfunction

    task automatic fill_img(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0: img[r][c] = 1'b1;
                    1: img[r][c] = !(r == 3 && c == 4);
                    2: img[r][c] = (r == 2 && c == 2);
                    default: img[r][c] = $urandom_range(7, 0) != 0;
                endcase
    endtask

    task automatic send(input bit b, input bit fs);
        int t = 0;
        bus.ena = 1'b1;
        bus.in_px = b ? 8'hFF : 8'h00;
        bus.frame_start = fs;
        while (!bus.in_ready) begin
            if (t++ > 200) begin
                chk("in_ready_timeout", 0, 1);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (fs) n_acc = 0;
        n_acc++;
        bus.ena = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic run_frame(input int id, input int kind, input int gap, input int ones_exp);
        int low = 0;
        int ones = 0;
        int fsn = 0;
        fill_img(kind);
        oq.delete();
        fq.delete();
        for (int i = 0; i < W * H; i++) begin
            send(img[i / W][i % W], i == 0);
            if (i != W * H - 1) repeat (gap < 0 ? $urandom_range(2, 0) : gap) @(negedge clk);
        end
        while (!bus.in_ready && low < 100) begin
            low++;
            @(negedge clk);
        end
        chk($sformatf("f%0d_flush_len", id), low, W + 1);
        repeat (2) @(negedge clk);
        chk($sformatf("f%0d_count", id), oq.size(), W * H);
        for (int i = 0; i < oq.size() && i < W * H; i++) begin
            chk($sformatf("f%0d_px_r%0d_c%0d", id, i / W, i % W), int'(oq[i]), model(i / W, i % W));
            ones += (oq[i] == 8'hFF) ? 1 : 0;
            fsn += int'(fq[i]);
        end
        if (ones_exp >= 0) chk($sformatf("f%0d_ones", id), ones, ones_exp);
        chk($sformatf("f%0d_fs_first", id), fq.size() > 0 ? int'(fq[0]) : 0, 1);
        chk($sformatf("f%0d_fs_count", id), fsn, 1);
        chk($sformatf("f%0d_first_latency", id), first_acc, W + 2);
    endtask

    initial begin
        vecs[0] = '{0, 0, 24};
        vecs[1] = '{1, 0, 15};
        vecs[2] = '{2, 0, 0};
        vecs[3] = '{0, 2, 24};
        vecs[4] = '{3, -1, -1};
        vecs[5] = '{3, 0, -1};
        bus.ena = 1'b0;
        bus.frame_start = 1'b0;
        bus.in_px = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_px", bus.out_px, 0);
        chk("reset_out_fs", bus.out_frame_start, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        oq.delete();
        for (int k = 0; k < 12; k++) send(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("idle_drop", oq.size(), 0);
        for (int i = 0; i < 6; i++) run_frame(i, vecs[i].kind, vecs[i].gap, vecs[i].ones);
        // Abort a frame at index 20 and restart with a clean full frame.
        for (int k = 0; k < 20; k++) send(1'b1, k == 0);
        run_frame(10, 0, 0, 24);
        for (int k = 0; k < 30; k++) send(1'b1, k == 0);
        chk("pre_reset_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", bus.out_valid, 0);
        chk("async_reset_px", bus.out_px, 0);
        chk("async_reset_in_ready", bus.in_ready, 1);
        oq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) send(1'b1, 1'b0);
        repeat (W + 4) @(negedge clk);
        chk("post_reset_quiet", oq.size(), 0);
        run_frame(11, 0, 0, 24);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
